muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 104 ++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit (32-cycle shift-add / restoring divide)
// Ports: clk, rst_n (async, active-low); start/kill control; funct3 op select;
//   A (rs1), B (rs2) operands; busy (RUN), done (one-cycle result pulse), result.
// Optional: define MULDIV_EARLY_OUT_EN to finish B=0, multiply-by-A=0 and signed
//   DIV/REM overflow in one cycle (IDLE->DONE) instead of the full 33 cycles.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        kill,
  input  logic [2:0]  funct3,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
`ifdef MULDIV_EARLY_OUT_EN
  localparam logic EARLY = 1'b1;
`else
  localparam logic EARLY = 1'b0;
`endif
  logic [1:0]  state;
  logic [4:0]  cnt;
  logic [2:0]  f_reg;
  logic [31:0] a_reg, b_reg, mc;
  logic [63:0] p, p_nxt, prod_s;
  logic [32:0] add_s, rem_sh, sub_s;
  logic [31:0] a_mag, b_mag, q_s, r_s, fin, special_val;
  logic        a_neg_in, b_neg_in, fa, fb, special;
  function automatic logic sgn_a(input logic [2:0] f);
    return f[2] ? ~f[0] : (f[1] ^ f[0]);
  endfunction
  function automatic logic sgn_b(input logic [2:0] f);
    return f[2] ? ~f[0] : (f[1:0] == 2'b01);
  endfunction
  // Datapath works on magnitudes; the sign is applied once when the result is captured.
  always_comb begin
    a_neg_in    = sgn_a(funct3) & A[31];
    b_neg_in    = sgn_b(funct3) & B[31];
    a_mag       = a_neg_in ? -A : A;
    b_mag       = b_neg_in ? -B : B;
    special     = (B == 32'd0) | (~funct3[2] & (A == 32'd0)) |
                  (funct3[2] & ~funct3[0] & (A == 32'h8000_0000) & (B == 32'hFFFF_FFFF));
    special_val = ~funct3[2] ? 32'd0 :
                  (B == 32'd0) ? (funct3[1] ? A : 32'hFFFF_FFFF) :
                  (funct3[1] ? 32'd0 : 32'h8000_0000);
    // Multiply: p = {acc, multiplier}; add multiplicand on lsb, shift right.
    add_s  = {1'b0, p[63:32]} + (p[0] ? {1'b0, mc} : 33'd0);
    // Divide: p = {remainder, dividend->quotient}; restoring shift-subtract.
    rem_sh = {p[63:32], p[31]};
    sub_s  = rem_sh - {1'b0, mc};
    p_nxt  = f_reg[2] ? (sub_s[32] ? {rem_sh[31:0], p[30:0], 1'b0} : {sub_s[31:0], p[30:0], 1'b1})
                      : {add_s, p[31:1]};
    fa     = sgn_a(f_reg) & a_reg[31];
    fb     = sgn_b(f_reg) & b_reg[31];
    prod_s = (fa ^ fb) ? -p_nxt : p_nxt;
    q_s    = (fa ^ fb) ? -p_nxt[31:0] : p_nxt[31:0];
    r_s    = fa ? -p_nxt[63:32] : p_nxt[63:32];
    // Divide-by-zero is overridden; signed overflow falls out of the magnitude path.
    fin    = f_reg[2] ? ((b_reg == 32'd0) ? (f_reg[1] ? a_reg : 32'hFFFF_FFFF) : (f_reg[1] ? r_s : q_s))
                      : ((f_reg[1:0] == 2'b00) ? prod_s[31:0] : prod_s[63:32]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= 5'd0;
      f_reg  <= 3'd0;
      a_reg  <= 32'd0;
      b_reg  <= 32'd0;
      mc     <= 32'd0;
      p      <= 64'd0;
      result <= 32'd0;
    end else begin
      case (state)
        IDLE: if (start && !kill) begin
          a_reg <= A;
          b_reg <= B;
          f_reg <= funct3;
          cnt   <= 5'd0;
          mc    <= funct3[2] ? b_mag : a_mag;
          p     <= {32'd0, funct3[2] ? a_mag : b_mag};
          if (EARLY && special) begin
            state  <= DONE;
            result <= special_val;
          end else state <= RUN;
        end
        RUN: if (kill) state <= IDLE;
        else begin
          p   <= p_nxt;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state  <= DONE;
            result <= fin;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign busy = (state == RUN);
  assign done = (state == DONE);
endmodule
